p2s_tx: RTL
===========

# p2s_tx

Parallel-to-serial frame transmitter, the sending end of the serial link that s2p receives. It accepts WIDTH-bit words through a valid/ready handshake into a one-entry holding buffer. Each word is shifted out one bit per clock with a bit-valid qualifier and frame markers. It streams the 40-bit multiplier product off-chip, and in loopback benches it drives s2p-style receivers.

## Interface
- WIDTH, 40: word and frame length in bits, 2..64.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- GAP, 1: idle cycles inserted after every frame, 0..15.
- clk  in  1  rising-edge clock, the single clock of the block.
- rst_n  in  1  asynchronous, active-low reset.
- din_vld  in  1  upstream word valid.
- din  in  WIDTH  upstream word, sampled on accept.
- din_rdy  out  1  buffer can take a word; equals ~buf_full.
- dout  out  1  serial data bit, registered.
- dout_vld  out  1  dout carries a frame bit this cycle.
- frame_start  out  1  high during the first bit of a frame.
- frame_last  out  1  high during the last bit of a frame.
- busy  out  1  high in SHIFT or GAP, or whenever buf_full.

## Operation
- Storage: holding buffer (buf, buf_full), shift register sr[WIDTH-1:0], bit counter bcnt (0..WIDTH-1), gap counter gcnt (0..GAP-1).
- Accept: at an edge with din_vld && din_rdy, buf <= din and buf_full <= 1. din_rdy is never asserted while buf_full, so accept and buffer-to-shifter transfer never coincide.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - if buf_full: load sr <= buf, clear buf_full, bcnt <= 0, go to SHIFT.
  - else stay in IDLE.
- SHIFT:
  - dout = sr[WIDTH-1] if MSB_FIRST, else sr[0]. sr shifts by one toward the output end each cycle, zero fill.
  - bcnt increments each cycle.
  - at bcnt==WIDTH-1 the frame ends. With GAP>0: go to GAP, gcnt <= 0. With GAP==0 and buf_full: reload directly, stay in SHIFT, so frames run back-to-back. With GAP==0 and buffer empty: go to IDLE.
- GAP:
  - dout_vld=0, dout=0.
  - gcnt increments.
  - at gcnt==GAP-1: if buf_full, reload and enter SHIFT; else go to IDLE.
- Outputs are all registered and decoded from next-state:
  - dout_vld=1 exactly in SHIFT cycles.
  - frame_start=1 when bcnt==0 in SHIFT.
  - frame_last=1 when bcnt==WIDTH-1 in SHIFT.
  - dout=0 whenever dout_vld=0.
- The word is captured whole on load. Later changes to din or buf do not affect the frame in flight.

## Timing
- Reset values:
  - dout=0, dout_vld=0, frame_start=0, frame_last=0, busy=0.
  - din_rdy=1, state=IDLE, buf_full=0, counters 0.
- Reset is asynchronous and takes effect immediately. Mid-frame reset aborts the frame and discards the buffered word. No partial-frame resumption after release.
- Latency from IDLE: accept at edge k, buf_full from k. Load at edge k+1, first bit valid in cycle k+1..k+2 with frame_start=1. frame_last falls in the WIDTH-th SHIFT cycle.
- Throughput: one frame per WIDTH+GAP cycles when the buffer is kept full.
  - din_rdy rises the cycle after each load, leaving upstream WIDTH+GAP-1 cycles to refill.
  - A refill that arrives in time gives no IDLE cycle between frames.
- Late refill: a buffer filled after the GAP or last-bit decision costs one IDLE cycle before loading.
- Every frame asserts frame_start and frame_last exactly once, including back-to-back frames, where frame_last of one frame is followed by frame_start of the next in the adjacent cycle.

## Test plan
- Single word, WIDTH=40, MSB_FIRST=1, GAP=1, din=40'h80_0000_0001 accepted at edge 1. Required: dout_vld high for exactly 40 cycles from edge 2; dout=1 first, 38 zeros, then 1; frame_start on bit 1, frame_last on bit 40; then one GAP cycle and return to IDLE with busy=0.
- Back-to-back, GAP=0: feed 40'hAAAA_AAAAAA then 40'h55_5555_5555 with din_vld held high. Required: dout_vld high for 80 consecutive cycles; frame_last on cycle 40, frame_start on cycle 41; alternating bit pattern with a phase flip at the boundary.
- Backpressure: offer three words consecutively. Required: word 1 accepted; din_rdy low one cycle, then word 2 accepted; din_rdy stays low until word 2 loads (frame 2 start); word 3 held stable by upstream and never dropped or duplicated.
- GAP=3: two queued words. Required: exactly 3 cycles with dout_vld=0 and dout=0 between frame_last and the next frame_start.
- LSB-first, MSB_FIRST=0, din=40'h00_0000_000B. Required: first four bits 1,1,0,1, then 36 zeros.
- Reset mid-frame: assert rst_n=0 at bit 17 with a second word buffered. Required: all outputs 0 and din_rdy=1 asynchronously. After release the line stays idle until a new word is accepted, and the buffered word is never sent.

Source files
------------

// File: rtl/p2s_tx.sv
// Parallel-to-serial frame transmitter: a one-entry holding buffer feeds a shift
// register that emits one bit per clock with frame markers and optional idle gaps.
module p2s_tx #(
  parameter int unsigned WIDTH     = 40,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned GAP       = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             din_vld_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             din_rdy_o,
  output logic             dout_o,
  output logic             dout_vld_o,
  output logic             frame_start_o,
  output logic             frame_last_o,
  output logic             busy_o
);

  localparam int unsigned    BCW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned    GCW       = 4;
  localparam logic [BCW-1:0] BCNT_LAST = BCW'(WIDTH - 1);
  localparam logic [GCW-1:0] GCNT_LAST = (GAP > 0) ? GCW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   buf_q, buf_d;
  logic               buf_full_q, buf_full_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [BCW-1:0]     bcnt_q, bcnt_d;
  logic [GCW-1:0]     gcnt_q, gcnt_d;
  logic               dout_q, dout_d;
  logic               dout_vld_q, dout_vld_d;
  logic               frame_start_q, frame_start_d;
  logic               frame_last_q, frame_last_d;

  logic               accept;
  logic               load;
  logic [WIDTH-1:0]   sr_shift;
  logic               out_bit;

  assign accept = din_vld_i && !buf_full_q;

  // Bit order only changes which end of the shifter feeds the line.
  if (MSB_FIRST) begin : g_msb_first
    assign sr_shift = {sr_q[WIDTH-2:0], 1'b0};
    assign out_bit  = sr_d[WIDTH-1];
  end else begin : g_lsb_first
    assign sr_shift = {1'b0, sr_q[WIDTH-1:1]};
    assign out_bit  = sr_d[0];
  end

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    sr_d       = sr_q;
    bcnt_d     = bcnt_q;
    gcnt_d     = gcnt_q;
    load       = 1'b0;

    if (accept) begin
      buf_d      = din_i;
      buf_full_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (buf_full_q) begin
          load = 1'b1;
        end
      end
      ST_SHIFT: begin
        sr_d   = sr_shift;
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == BCNT_LAST) begin
          bcnt_d = '0;
          if (GAP > 0) begin
            state_d = ST_GAP;
            gcnt_d  = '0;
          end else if (buf_full_q) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        gcnt_d = gcnt_q + 1'b1;
        if (gcnt_q == GCNT_LAST) begin
          gcnt_d = '0;
          if (buf_full_q) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Load never coincides with accept: accept needs an empty buffer, load a full one.
    if (load) begin
      sr_d       = buf_q;
      buf_full_d = 1'b0;
      bcnt_d     = '0;
      state_d    = ST_SHIFT;
    end
  end

  always_comb begin
    dout_vld_d    = (state_d == ST_SHIFT);
    frame_start_d = dout_vld_d && (bcnt_d == '0);
    frame_last_d  = dout_vld_d && (bcnt_d == BCNT_LAST);
    dout_d        = dout_vld_d && out_bit;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      buf_q         <= '0;
      buf_full_q    <= 1'b0;
      sr_q          <= '0;
      bcnt_q        <= '0;
      gcnt_q        <= '0;
      dout_q        <= 1'b0;
      dout_vld_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_last_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      buf_full_q    <= buf_full_d;
      sr_q          <= sr_d;
      bcnt_q        <= bcnt_d;
      gcnt_q        <= gcnt_d;
      dout_q        <= dout_d;
      dout_vld_q    <= dout_vld_d;
      frame_start_q <= frame_start_d;
      frame_last_q  <= frame_last_d;
    end
  end

  assign din_rdy_o     = ~buf_full_q;
  assign dout_o        = dout_q;
  assign dout_vld_o    = dout_vld_q;
  assign frame_start_o = frame_start_q;
  assign frame_last_o  = frame_last_q;
  assign busy_o        = (state_q != ST_IDLE) || buf_full_q;

endmodule
